hazard_seq_ctrl: RTL and testbench
==================================

HAZARD_SEQ_CTRL -- requirements
Module: hazard_seq_ctrl

Interface
REQ-001 SHALL have parameter MC_CYCLES, default 4: number of Execute cycles a multi-cycle op occupies, legal range 2..15.
REQ-002 SHALL have port clk, input, 1: rising-edge clock.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port RA1D, input, 4: Decode source register 1.
REQ-005 SHALL have port RA2D, input, 4: Decode source register 2.
REQ-006 SHALL have port WA3E, input, 4: Execute destination register.
REQ-007 SHALL have port RegWriteE, input, 1: Execute instruction writes a register.
REQ-008 SHALL have port MemtoRegE, input, 1: Execute instruction is a load.
REQ-009 SHALL have port BranchTakenE, input, 1: taken branch resolved in Execute.
REQ-010 SHALL have port StartMcE, input, 1: multi-cycle op present in Execute.
REQ-011 SHALL have port StallF, output, 1: en=0 for the Fetch PC register.
REQ-012 SHALL have port StallD, output, 1: en=0 for the Fetch/Decode register.
REQ-013 SHALL have port FlushD, output, 1: clear for the Fetch/Decode register.
REQ-014 SHALL have port StallE, output, 1: en=0 for the Decode/Execute register.
REQ-015 SHALL have port FlushE, output, 1: clear for the Decode/Execute register.
REQ-016 SHALL have port FlushM, output, 1: clear for the Execute/Memory register (bubble).
REQ-017 SHALL have port McBusy, output, 1: registered; multi-cycle sequencer is in BUSY.
REQ-018 SHALL have port McDone, output, 1: registered; one-cycle pulse marking the final Execute cycle.

Function
REQ-019 SHALL use FSM states IDLE, BUSY, DONE and a 4-bit down-counter cnt.
REQ-020 In IDLE, StartMcE=1 and BranchTakenE=0 SHALL move to BUSY with cnt=MC_CYCLES-2 at the next edge.
REQ-021 In BUSY, cnt SHALL decrement each cycle; cnt==0 SHALL move to DONE.
REQ-022 DONE SHALL last exactly one cycle, then move to IDLE; StartMcE is ignored in DONE.
REQ-023 Total Execute occupancy from StartMcE accept to release SHALL be exactly MC_CYCLES cycles.
REQ-024 McBusy=1 iff state==BUSY; McDone=1 iff state==DONE.
REQ-025 In the accept cycle and in BUSY, the block SHALL assert StallF=StallD=StallE=1 and FlushM=1.
REQ-026 In DONE, StallF, StallD, StallE and FlushM SHALL be 0, letting the result advance.
REQ-027 Load-use (ldu) = MemtoRegE & RegWriteE & (WA3E==RA1D | WA3E==RA2D); when ldu=1 in IDLE, StallF=StallD=1 and FlushE=1.
REQ-028 BranchTakenE=1 SHALL assert FlushD=FlushE=1 and override ldu stalls (StallF=StallD=0) in the same cycle.
REQ-029 BranchTakenE together with StartMcE in IDLE: the branch wins, no BUSY entry.
REQ-030 Outside the conditions above, all stall and flush outputs SHALL be 0.
REQ-031 Only StallF, StallD, FlushD, StallE, FlushE and FlushM SHALL be combinational; McBusy and McDone SHALL be flop outputs.

Reset
REQ-032 Asserted reset SHALL immediately force state=IDLE, cnt=0, McBusy=0, McDone=0.
REQ-033 Reset asserted mid-BUSY SHALL abort the op, with no McDone pulse after release.
REQ-034 While reset=1, all stall and flush outputs SHALL read 0.

Configuration
REQ-035 With macro MULTICYCLE_SEQ_EN defined, the FSM, counter and REQ-019..026 SHALL be compiled in.
REQ-036 Without MULTICYCLE_SEQ_EN, StartMcE SHALL be ignored; McBusy, McDone, StallE and FlushM SHALL be tied 0; ldu and branch logic stay unchanged.

Verification
REQ-037 Load-use: MemtoRegE=1, RegWriteE=1, WA3E=3, RA2D=3 -> same cycle StallF=StallD=FlushE=1, FlushD=0.
REQ-038 Multi-cycle op, MC_CYCLES=4: StartMcE pulse at cycle t -> stalls and FlushM high at t..t+2; McBusy high t+1..t+2; McDone high at t+3 with stalls low.
REQ-039 Branch plus load-use: BranchTakenE=1 with ldu=1 -> FlushD=FlushE=1, StallF=StallD=0.
REQ-040 Branch plus StartMcE in IDLE -> FlushD=FlushE=1, McBusy stays 0 at the next cycle.
REQ-041 Reset at the 2nd BUSY cycle -> McBusy=0 immediately, no McDone pulse; a new StartMcE is then accepted normally.
REQ-042 MULTICYCLE_SEQ_EN undefined, StartMcE=1 for 5 cycles -> McBusy, McDone, StallE and FlushM stay 0.

Source files
------------

// File: rtl/hazard_seq_ctrl.sv
// hazard_seq_ctrl: pipeline hazard control for a 5-stage core.
// Generates load-use stalls, taken-branch flushes and, when the macro
// MULTICYCLE_SEQ_EN is defined, sequences a multi-cycle Execute op that
// holds Fetch/Decode/Execute for MC_CYCLES cycles and bubbles Memory.
// Without MULTICYCLE_SEQ_EN, StartMcE is ignored and McBusy, McDone,
// StallE and FlushM read 0.
module hazard_seq_ctrl #(
  parameter int unsigned MC_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] WA3E,
  input  logic       RegWriteE,
  input  logic       MemtoRegE,
  input  logic       BranchTakenE,
  input  logic       StartMcE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       StallE,
  output logic       FlushE,
  output logic       FlushM,
  output logic       McBusy,
  output logic       McDone
);

  localparam int unsigned CNT_W = 4;
  // Counter load on accept: number of BUSY cycles between accept and DONE.
  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_CYCLES - 2);

  logic ldu_c;

  // Load in Execute whose destination feeds a Decode source operand.
  assign ldu_c = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));

`ifdef MULTICYCLE_SEQ_EN

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mc_busy_q, mc_busy_d;
  logic             mc_done_q, mc_done_d;
  logic             accept_c;

  // Sequencer state, counter and registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mc_busy_q <= 1'b0;
      mc_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mc_busy_q <= mc_busy_d;
      mc_done_q <= mc_done_d;
    end
  end

  // Next state and hazard outputs; a branch blocks acceptance of a new op.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept_c  = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    StallE    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;

    case (state_q)
      IDLE: begin
        if (StartMcE && !BranchTakenE) begin
          accept_c = 1'b1;
          // A two-cycle op has no BUSY phase: accept, then final cycle.
          if (MC_LOAD == '0) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            state_d = BUSY;
            cnt_d   = MC_LOAD;
          end
        end
      end
      BUSY: begin
        // Leave BUSY as the count reaches zero so DONE is the last cycle.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (!reset) begin
      if (accept_c || (state_q == BUSY)) begin
        // Hold the op in Execute and feed bubbles into Memory.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else begin
        if ((state_q == IDLE) && ldu_c) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
        if (BranchTakenE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
          StallF = 1'b0;
          StallD = 1'b0;
        end
      end
    end

    mc_busy_d = (state_d == BUSY);
    mc_done_d = (state_d == DONE);
  end

  assign McBusy = mc_busy_q;
  assign McDone = mc_done_q;

`else

  logic mc_busy_q, mc_done_q;
  logic unused_ok;

  // Status flags exist as flops but stay cleared when sequencing is absent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mc_busy_q <= 1'b0;
      mc_done_q <= 1'b0;
    end else begin
      mc_busy_q <= 1'b0;
      mc_done_q <= 1'b0;
    end
  end

  // Load-use stall and branch flush only; branch overrides the stall.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    StallE = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (!reset) begin
      if (ldu_c) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      if (BranchTakenE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
        StallF = 1'b0;
        StallD = 1'b0;
      end
    end
  end

  assign McBusy    = mc_busy_q;
  assign McDone    = mc_done_q;
  assign unused_ok = ^{StartMcE, MC_LOAD};

`endif

endmodule

// File: tb/tb_hazard_seq_ctrl.sv
// Bench for hazard_seq_ctrl: reference model tracks how many Execute
// cycles of a multi-cycle op remain; expectations are queued per cycle
// and a negedge monitor compares them against the DUT outputs.
module tb_hazard_seq_ctrl;

  localparam int unsigned MC = 4;
`ifdef MULTICYCLE_SEQ_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, WA3E;
  logic       RegWriteE, MemtoRegE, BranchTakenE, StartMcE;
  logic       StallF, StallD, FlushD, StallE, FlushE, FlushM, McBusy, McDone;

  always #5 clk = ~clk;

  hazard_seq_ctrl #(.MC_CYCLES(MC)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .WA3E(WA3E),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .BranchTakenE(BranchTakenE), .StartMcE(StartMcE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .StallE(StallE),
    .FlushE(FlushE), .FlushM(FlushM), .McBusy(McBusy), .McDone(McDone)
  );

  typedef struct {
    logic [7:0] exp;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;
  int   mc_left = 0;   // remaining Execute cycles of the op after this one

  function automatic logic [7:0] outs();
    return {StallF, StallD, FlushD, StallE, FlushE, FlushM, McBusy, McDone};
  endfunction

  task automatic check_now(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b required %b (SF,SD,FD,SE,FE,FM,Busy,Done)", name, got, want);
    end
  endtask

  // One clock of stimulus plus the model's expectation for that cycle.
  task automatic drive(input logic st, input logic br, input logic mr, input logic rw,
                       input logic [3:0] wa, input logic [3:0] r1, input logic [3:0] r2);
    logic ldu, idle, busy, done, acc, mcst;
    logic sf, sd, fd, se, fe, fm;
    exp_t e;
    @(posedge clk);
    #1;
    StartMcE = st; BranchTakenE = br; MemtoRegE = mr; RegWriteE = rw;
    WA3E = wa; RA1D = r1; RA2D = r2;
    cyc_no++;
    ldu  = mr && rw && ((wa == r1) || (wa == r2));
    idle = (mc_left == 0);
    busy = (mc_left > 1);
    done = (mc_left == 1);
    acc  = EN && idle && st && !br;
    mcst = acc || busy;
    sf = mcst || (idle && ldu && !br);
    sd = sf;
    se = mcst;
    fm = mcst;
    fd = br && !mcst;
    fe = (br && !mcst) || (idle && ldu && !br && !acc);
    e.exp = {sf, sd, fd, se, fe, fm, busy, done};
    e.cyc = cyc_no;
    sb_q.push_back(e);
    if (acc) mc_left = MC - 1;
    else if (mc_left > 0) mc_left--;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2);
  endtask

  // Random cycle; while an op occupies Execute no load or branch is there.
  task automatic rand_cycle();
    logic st, br, mr, rw;
    st = ($urandom_range(0, 5) == 0);
    br = ($urandom_range(0, 4) == 0);
    mr = $urandom_range(0, 1) == 1;
    rw = $urandom_range(0, 3) != 0;
    if (mc_left > 0) begin
      br = 1'b0;
      mr = 1'b0;
      st = $urandom_range(0, 1) == 1;
    end
    if (st) mr = 1'b0;
    drive(st, br, mr, rw, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
          4'($urandom_range(0, 3)));
  endtask

  // Asynchronous reset mid-cycle with hazard-producing inputs present.
  task automatic mid_reset(input string name);
    @(negedge clk);
    #2;
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA1D = 4'd5; RA2D = 4'd5;
    BranchTakenE = 1'b1; StartMcE = 1'b1;
    reset = 1'b1;
    #1;
    check_now(name, outs(), 8'h00);
    mc_left = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_now({name, "_held"}, outs(), 8'h00);
    @(negedge clk);
    #1;
    StartMcE = 1'b0; BranchTakenE = 1'b0; MemtoRegE = 1'b0;
    reset = 1'b0;
  endtask

  // Monitor: compare the queued expectation for the current cycle.
  always @(negedge clk) begin
    exp_t x;
    if (!reset && (sb_q.size() > 0)) begin
      x = sb_q.pop_front();
      checks++;
      if (outs() !== x.exp) begin
        errors++;
        $display("FAIL cycle_%0d outputs: got %b required %b (SF,SD,FD,SE,FE,FM,Busy,Done)",
                 x.cyc, outs(), x.exp);
      end
    end
  end

  initial begin
    reset = 1'b1;
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd3; RA1D = 4'd3; RA2D = 4'd3;
    BranchTakenE = 1'b1; StartMcE = 1'b1;
    #3;
    check_now("reset_state", outs(), 8'h00);
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0; StartMcE = 1'b0; BranchTakenE = 1'b0; MemtoRegE = 1'b0;

    // Load-use on RA2D, then on RA1D, then near misses.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 4'd5, 4'd3);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 4'd7, 4'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 4'd5, 4'd6);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd3, 4'd3);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd3, 4'd3);
    // Branch alone and branch overriding a load-use stall.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 4'd3, 4'd3);
    // Branch together with a start: branch wins, nothing starts.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2);
    idle_cycle();
    idle_cycle();

    // Start held high for a whole op and beyond (ignored in final cycle).
    repeat (MC + 1) drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2);
    repeat (MC + 1) idle_cycle();

    // Single start pulse, then abort with reset on the second BUSY cycle.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2);
    idle_cycle();
    idle_cycle();
    mid_reset("reset_mid_op");
    repeat (MC + 1) idle_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2);
    repeat (MC + 1) idle_cycle();

    repeat (400) rand_cycle();
    mid_reset("reset_random");
    repeat (100) rand_cycle();
    repeat (MC + 1) idle_cycle();

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
